// File: rtl/cp0.sv
// Coprocessor-0 for the multi-cycle MIPS core: SR, Cause, EPC and PrID registers,
// mfc0/mtc0 access, and synchronisation of the six hardware interrupt lines.
module cp0 #(
  parameter logic [31:0] PRID        = 32'h0000_0001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pcout,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        wen,
  input  logic        exl_set,
  input  logic        exl_clr,
  input  logic [5:0]  hwint,
  output logic        irq,
  output logic [29:0] epc,
  output logic [31:0] dout
);

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [29:0] r_epc;

  logic [5:0]  w_ip;
  logic        w_wr_sr;
  logic        w_wr_epc;

  assign w_ip     = r_sync[SYNC_STAGES-1];
  assign w_wr_sr  = wen && (sel == 5'd12);
  assign w_wr_epc = wen && (sel == 5'd14);

  // Shift chain: stage 0 samples hwint, the last stage is Cause.IP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      for (int unsigned k = SYNC_STAGES - 1; k > 0; k--) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_sync[0] <= hwint;
    end
  end

  // exl_set outranks exl_clr, which outranks an mtc0 write of the EXL bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_epc <= '0;
    end else begin
      if (w_wr_sr) begin
        r_im <= din[15:10];
        r_ie <= din[0];
      end

      if (exl_set) begin
        r_exl <= 1'b1;
      end else if (exl_clr) begin
        r_exl <= 1'b0;
      end else if (w_wr_sr) begin
        r_exl <= din[1];
      end

      if (exl_set) begin
        r_epc <= pcout;
      end else if (w_wr_epc) begin
        r_epc <= din[31:2];
      end
    end
  end

  assign irq = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign epc = r_epc;

  always_comb begin
    dout = '0;
    case (sel)
      5'd12:   dout = {16'h0000, r_im, 8'h00, r_exl, r_ie};
      5'd13:   dout = {16'h0000, w_ip, 10'h000};
      5'd14:   dout = {r_epc, 2'b00};
      5'd15:   dout = PRID;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed vector table from reset, a reset-during-write sequence,
// and a randomized run checked against a rule-level reference model.
module tb_cp0;

  localparam logic [31:0] PRID        = 32'h0000_0001;
  localparam int unsigned SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] pcout = '0;
  logic [4:0]  sel = '0;
  logic [31:0] din = '0;
  logic        wen = 1'b0;
  logic        exl_set = 1'b0;
  logic        exl_clr = 1'b0;
  logic [5:0]  hwint = '0;
  logic        irq;
  logic [29:0] epc;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  cp0 #(.PRID(PRID), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .pcout(pcout), .sel(sel), .din(din), .wen(wen),
    .exl_set(exl_set), .exl_clr(exl_clr), .hwint(hwint),
    .irq(irq), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  s;
    logic [31:0] d;
    logic        st;
    logic        cl;
    logic [5:0]  h;
    logic [29:0] p;
    logic [4:0]  rs;
    logic [31:0] xd;
    logic        xi;
    logic [29:0] xe;
  } vec_t;

  function automatic vec_t mk(logic w, logic [4:0] s, logic [31:0] d, logic st, logic cl,
                              logic [5:0] h, logic [29:0] p, logic [4:0] rs,
                              logic [31:0] xd, logic xi, logic [29:0] xe);
    vec_t v;
    v.w = w; v.s = s; v.d = d; v.st = st; v.cl = cl; v.h = h; v.p = p;
    v.rs = rs; v.xd = xd; v.xi = xi; v.xe = xe;
    return v;
  endfunction

  // Reference model: architectural fields plus a delay queue for interrupt lines.
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie;
  logic [29:0] m_epc;
  logic [5:0]  m_q[$];

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_exl = 1'b0; m_ie = 1'b0; m_epc = '0;
    m_q.delete();
    for (int i = 0; i < int'(SYNC_STAGES) - 1; i++) m_q.push_back(6'h0);
  endtask

  task automatic model_edge();
    logic [5:0]  n_im;
    logic        n_exl, n_ie;
    logic [29:0] n_epc;
    n_im = m_im; n_exl = m_exl; n_ie = m_ie; n_epc = m_epc;
    if (wen && sel == 5'd12) begin
      n_im = din[15:10]; n_ie = din[0]; n_exl = din[1];
    end
    if (wen && sel == 5'd14) n_epc = din / 4;
    if (exl_clr) n_exl = 1'b0;
    if (exl_set) begin
      n_exl = 1'b1; n_epc = pcout;
    end
    m_q.push_back(hwint);
    m_ip = m_q.pop_front();
    m_im = n_im; m_exl = n_exl; m_ie = n_ie; m_epc = n_epc;
  endtask

  function automatic logic [31:0] model_dout(logic [4:0] s);
    case (s)
      5'd12:   return 32'(m_im) * 1024 + 32'(m_exl) * 2 + 32'(m_ie);
      5'd13:   return 32'(m_ip) * 1024;
      5'd14:   return 32'(m_epc) * 4;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    return ((m_ip & m_im) != 6'h0) && m_ie && !m_exl;
  endfunction

  vec_t tbl[$];

  initial begin
    // Reset state (async, before any clock edge)
    #1;
    sel = 5'd12; #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_epc", 32'(epc), 32'h0);
    chk("rst_sr", dout, 32'h0);
    sel = 5'd15; #1;
    chk("rst_prid", dout, PRID);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Build up state, then assert reset in the middle of an SR write
    wen = 1'b1; sel = 5'd12; din = 32'h0000_FC01; hwint = 6'h3F;
    @(posedge clk); #1;
    sel = 5'd14; din = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_irq", 32'(irq), 32'h1);
    chk("pre_epc", 32'(epc), 32'h3FFF_FFFF);
    @(negedge clk);
    wen = 1'b1; sel = 5'd12; din = 32'hFFFF_FFFF;
    #1 rst = 1'b1;
    #1;
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_epc", 32'(epc), 32'h0);
    chk("midrst_sr", dout, 32'h0);
    sel = 5'd15; #1;
    chk("midrst_prid", dout, PRID);
    sel = 5'd12;
    @(posedge clk);
    #1 rst = 1'b0; wen = 1'b0; hwint = 6'h0;
    #1;
    chk("postrst_sr", dout, 32'h0);
    sel = 5'd13; #1;
    chk("postrst_cause", dout, 32'h0);

    //            w  sel    din            set clr hw     pc             rsel   dout           irq epc
    tbl.push_back(mk(1, 5'd12, 32'h0000_FC01, 0, 0, 6'h00, 30'h0,          5'd12, 32'h0000_FC01, 0, 30'h0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h04, 30'h0,          5'd13, 32'h0000_0000, 0, 30'h0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h04, 30'h0,          5'd13, 32'h0000_1000, 1, 30'h0));
    tbl.push_back(mk(0, 5'd0,  32'h0,         1, 0, 6'h04, 30'h0000_0C05,  5'd14, 32'h0000_3014, 0, 30'h0C05));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h04, 30'h0,          5'd12, 32'h0000_FC03, 0, 30'h0C05));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 1, 6'h04, 30'h0,          5'd12, 32'h0000_FC01, 1, 30'h0C05));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h00, 30'h0,          5'd13, 32'h0000_1000, 1, 30'h0C05));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h00, 30'h0,          5'd13, 32'h0000_0000, 0, 30'h0C05));
    tbl.push_back(mk(1, 5'd14, 32'hDEAD_BEEC, 1, 1, 6'h00, 30'h10,         5'd12, 32'h0000_FC03, 0, 30'h10));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h00, 30'h0,          5'd14, 32'h0000_0040, 0, 30'h10));
    tbl.push_back(mk(1, 5'd12, 32'h0000_0401, 1, 0, 6'h00, 30'h3FFF_FFFF,  5'd12, 32'h0000_0403, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h00, 30'h0,          5'd14, 32'hFFFF_FFFC, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd12, 32'h0000_FC03, 0, 1, 6'h00, 30'h0,          5'd12, 32'h0000_FC01, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd12, 32'h0000_FC00, 0, 0, 6'h04, 30'h0,          5'd12, 32'h0000_FC00, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(0, 5'd0,  32'h0,         0, 0, 6'h04, 30'h0,          5'd13, 32'h0000_1000, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd12, 32'h0000_EC01, 0, 0, 6'h04, 30'h0,          5'd12, 32'h0000_EC01, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd13, 32'hFFFF_FFFF, 0, 0, 6'h04, 30'h0,          5'd13, 32'h0000_1000, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd15, 32'h0,         0, 0, 6'h04, 30'h0,          5'd15, PRID,          0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd7,  32'hFFFF_FFFF, 0, 0, 6'h04, 30'h0,          5'd7,  32'h0000_0000, 0, 30'h3FFF_FFFF));
    tbl.push_back(mk(1, 5'd12, 32'h0000_FC01, 0, 0, 6'h04, 30'h0,          5'd12, 32'h0000_FC01, 1, 30'h3FFF_FFFF));
    tbl.push_back(mk(0, 5'd0,  32'h0,         1, 0, 6'h04, 30'h123,        5'd14, 32'h0000_048C, 0, 30'h123));
    tbl.push_back(mk(0, 5'd0,  32'h0,         1, 0, 6'h04, 30'h2AAA_AAAA,  5'd12, 32'h0000_FC03, 0, 30'h2AAA_AAAA));
    tbl.push_back(mk(1, 5'd14, 32'h1234_5678, 0, 0, 6'h04, 30'h0,          5'd14, 32'h1234_5678, 0, 30'h048D_159E));

    foreach (tbl[i]) begin
      wen = tbl[i].w; sel = tbl[i].s; din = tbl[i].d;
      exl_set = tbl[i].st; exl_clr = tbl[i].cl; hwint = tbl[i].h; pcout = tbl[i].p;
      @(posedge clk); #1;
      wen = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; sel = tbl[i].rs;
      #1;
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].xd);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].xi));
      chk($sformatf("vec%0d_epc", i), 32'(epc), 32'(tbl[i].xe));
    end

    // Randomized run against the reference model, with occasional resets
    rst = 1'b1; wen = 1'b0; exl_set = 1'b0; exl_clr = 1'b0; hwint = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      wen     = ($urandom_range(0, 2) == 0);
      sel     = ($urandom_range(0, 3) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      din     = $urandom;
      exl_set = ($urandom_range(0, 9) == 0);
      exl_clr = ($urandom_range(0, 7) == 0);
      pcout   = 30'($urandom);
      if ($urandom_range(0, 3) == 0) hwint = 6'($urandom);
      if (rst) model_reset();
      #2;
      chk("rnd_dout", dout, model_dout(sel));
      chk("rnd_irq", 32'(irq), 32'(model_irq()));
      chk("rnd_epc", 32'(epc), 32'(m_epc));
      @(posedge clk);
      if (!rst) model_edge();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
